// File: rtl/fpu_addsub_pkg.sv
// Shared constants for the FP add/subtract datapath: default field widths,
// operation encoding and IEEE-754 field positions for the default word.
package fpu_addsub_pkg;

    localparam int DEF_W  = 32;
    localparam int DEF_EW = 8;
    localparam int DEF_SW = 23;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int SIGN_BIT = DEF_W - 1;
    localparam int EXP_MSB  = DEF_W - 2;
    localparam int EXP_LSB  = DEF_SW;
    localparam int MANT_MSB = DEF_SW - 1;
    localparam int MANT_LSB = 0;

endpackage

// File: rtl/mag_comparator.sv
// Unsigned magnitude comparator for the exponent+mantissa field.
module mag_comparator #(
    parameter int N = 31
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         gt,
    output logic         eq
);

    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/addsub_cmp_swap_stage.sv
// Front-end stage of the FP add/sub datapath: registers operands, compares
// magnitudes, routes max/min lanes and resolves the result sign.
module addsub_cmp_swap_stage #(
    parameter int W  = fpu_addsub_pkg::DEF_W,
    parameter int EW = fpu_addsub_pkg::DEF_EW,
    parameter int SW = fpu_addsub_pkg::DEF_SW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         add_subt_i,
    input  logic [W-1:0] data_x_i,
    input  logic [W-1:0] data_y_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-2:0] dmax_o,
    output logic [W-2:0] dmin_o,
    output logic         add_subt_o,
    output logic         eff_sub_o,
    output logic         gtXY_o,
    output logic         eqXY_o,
    output logic         sgn_result_o
);

    import fpu_addsub_pkg::*;

    logic         s1_valid;
    logic         s1_op;
    logic [W-1:0] s1_x;
    logic [W-1:0] s1_y;
    logic         s2_valid;
    logic         en1;
    logic         en2;

    logic [W-2:0] mag_x;
    logic [W-2:0] mag_y;
    logic         gt_xy;
    logic         eq_xy;
    logic         sgn_x;
    logic         eff_sign_y;
    logic         sgn_next;

    assign en2       = ~s2_valid | out_ready;
    assign en1       = ~s1_valid | en2;
    assign in_ready  = en1 & rst_n;
    assign out_valid = s2_valid;

    assign mag_x      = {s1_x[W-2 -: EW], s1_x[SW-1:0]};
    assign mag_y      = {s1_y[W-2 -: EW], s1_y[SW-1:0]};
    assign sgn_x      = s1_x[W-1];
    assign eff_sign_y = s1_op ^ s1_y[W-1];

    mag_comparator #(.N(W-1)) u_mag_cmp (
        .a  (mag_x),
        .b  (mag_y),
        .gt (gt_xy),
        .eq (eq_xy)
    );

    // Equal magnitudes with opposite effective signs cancel to +0.
    always_comb begin
        sgn_next = eff_sign_y;
        if (gt_xy)
            sgn_next = sgn_x;
        else if (eq_xy)
            sgn_next = sgn_x & eff_sign_y;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_op        <= OP_ADD;
            s1_x         <= '0;
            s1_y         <= '0;
            s2_valid     <= 1'b0;
            dmax_o       <= '0;
            dmin_o       <= '0;
            add_subt_o   <= 1'b0;
            eff_sub_o    <= 1'b0;
            gtXY_o       <= 1'b0;
            eqXY_o       <= 1'b0;
            sgn_result_o <= 1'b0;
        end else begin
            if (en1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op <= add_subt_i;
                    s1_x  <= data_x_i;
                    s1_y  <= data_y_i;
                end
            end
            // Payload only moves with a real pair, so it stays put across bubbles.
            if (en2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    dmax_o       <= gt_xy ? mag_x : mag_y;
                    dmin_o       <= gt_xy ? mag_y : mag_x;
                    add_subt_o   <= s1_op;
                    eff_sub_o    <= sgn_x ^ eff_sign_y;
                    gtXY_o       <= gt_xy;
                    eqXY_o       <= eq_xy;
                    sgn_result_o <= sgn_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_cmp_swap_stage.sv
// Randomized self-checking bench for addsub_cmp_swap_stage with a queue-based
// reference model and a few directed vectors.
module tb_addsub_cmp_swap_stage;
    import fpu_addsub_pkg::*;

    typedef struct packed {
        logic [30:0] dmax;
        logic [30:0] dmin;
        logic        op;
        logic        eff_sub;
        logic        gt;
        logic        eq;
        logic        sgn;
    } res_t;

    typedef struct {
        res_t r;
        int   acc;
    } ent_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic        add_subt_i = 0;
    logic [31:0] data_x_i = 0;
    logic [31:0] data_y_i = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [30:0] dmax_o;
    logic [30:0] dmin_o;
    logic        add_subt_o;
    logic        eff_sub_o;
    logic        gtXY_o;
    logic        eqXY_o;
    logic        sgn_result_o;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   after_rst = 0;
    bit   prev_stall = 0;
    res_t prev_pay;

    addsub_cmp_swap_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .add_subt_i   (add_subt_i),
        .data_x_i     (data_x_i),
        .data_y_i     (data_y_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .dmax_o       (dmax_o),
        .dmin_o       (dmin_o),
        .add_subt_o   (add_subt_o),
        .eff_sub_o    (eff_sub_o),
        .gtXY_o       (gtXY_o),
        .eqXY_o       (eqXY_o),
        .sgn_result_o (sgn_result_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sign taken from the signed sum X + (+/-Y); an exact zero is +0 unless both terms are negative.
    function automatic res_t ref_model(logic [31:0] x, logic [31:0] y, logic op);
        res_t   r;
        longint mx, my, vx, vy, sum;
        logic   sx, effy;
        mx   = longint'(x[30:0]);
        my   = longint'(y[30:0]);
        sx   = x[31];
        effy = op ^ y[31];
        vx   = sx ? -mx : mx;
        vy   = effy ? -my : my;
        sum  = vx + vy;
        r.gt      = (mx > my);
        r.eq      = (mx == my);
        r.dmax    = (mx > my) ? x[30:0] : y[30:0];
        r.dmin    = (mx > my) ? y[30:0] : x[30:0];
        r.op      = op;
        r.eff_sub = sx ^ effy;
        r.sgn     = (sum < 0) ? 1'b1 : (sum > 0) ? 1'b0 : (sx & effy);
        return r;
    endfunction

    function automatic res_t dut_pay();
        return {dmax_o, dmin_o, add_subt_o, eff_sub_o, gtXY_o, eqXY_o, sgn_result_o};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                check("in_ready_in_reset", in_ready, 0);
                q.delete();
                after_rst  = 1;
                prev_stall = 0;
            end else begin
                if (after_rst) begin
                    check("post_reset_zero", {out_valid, dut_pay()}, 0);
                    after_rst = 0;
                end
                check("in_ready", in_ready, (q.size() < 2) || out_ready);
                check("out_valid", out_valid, (q.size() > 0) && (cyc >= q[0].acc + 1));
                if (prev_stall)
                    check("stall_stable", dut_pay(), prev_pay);
                if (out_valid && q.size() > 0)
                    check("payload", dut_pay(), q[0].r);
                prev_stall = out_valid && !out_ready;
                prev_pay   = dut_pay();
                if (out_valid && out_ready && q.size() > 0)
                    void'(q.pop_front());
                if (in_valid && in_ready)
                    q.push_back('{ref_model(data_x_i, data_y_i, add_subt_i), cyc + 1});
            end
        end
    end

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid  = 0;
            out_ready = 1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        in_valid  = 0;
        out_ready = 1;
        while (q.size() > 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic directed(string name, logic [31:0] x, logic [31:0] y, logic op,
                            logic gt, logic eq, logic [30:0] dmax, logic [30:0] dmin,
                            logic sgn, logic eff);
        idle(3);
        @(posedge clk); #1;
        in_valid = 1; out_ready = 1; data_x_i = x; data_y_i = y; add_subt_i = op;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        check({name, "_valid"}, out_valid, 1);
        check({name, "_flags"}, {gtXY_o, eqXY_o, sgn_result_o, eff_sub_o, add_subt_o},
              {gt, eq, sgn, eff, op});
        check({name, "_lanes"}, {dmax_o, dmin_o}, {dmax, dmin});
    endtask

    task automatic rand_pair();
        logic [31:0] x, y;
        int mode;
        x    = $urandom;
        mode = $urandom_range(0, 9);
        if (mode < 3)
            y = {1'($urandom), x[30:0]};
        else if (mode < 5)
            y = {1'($urandom), x[30:0] + 31'($urandom_range(0, 2)) - 31'd1};
        else
            y = $urandom;
        data_x_i   = x;
        data_y_i   = y;
        add_subt_i = 1'($urandom);
    endtask

    initial begin
        res_t r;
        int sent;
        bit seen_block;
        int pat[6] = '{1, 0, 0, 1, 1, 0};

        // Model pins against hand-computed values.
        r = ref_model(32'h40400000, 32'h40000000, OP_ADD);
        check("pin_add", {r.gt, r.eq, r.sgn, r.eff_sub, r.dmax, r.dmin},
              {1'b1, 1'b0, 1'b0, 1'b0, 31'h40400000, 31'h40000000});
        r = ref_model(32'hBF800000, 32'hBF800000, OP_ADD);
        check("pin_neg_eq", {r.eq, r.sgn}, {1'b1, 1'b1});
        r = ref_model(32'h3F800000, 32'h40000000, OP_SUB);
        check("pin_small_x", {r.gt, r.sgn, r.dmax}, {1'b0, 1'b1, 31'h40000000});

        mon_en = 1;
        rst_n  = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        check("reset_out_valid", out_valid, 0);
        check("reset_flags", {gtXY_o, eqXY_o, sgn_result_o}, 0);

        directed("basic_add", 32'h40400000, 32'h40000000, OP_ADD,
                 1, 0, 31'h40400000, 31'h40000000, 0, 0);
        directed("cancel_pos", 32'h3F800000, 32'h3F800000, OP_SUB,
                 0, 1, 31'h3F800000, 31'h3F800000, 0, 1);
        directed("cancel_neg", 32'hBF800000, 32'hBF800000, OP_ADD,
                 0, 1, 31'h3F800000, 31'h3F800000, 1, 0);
        directed("small_x_sub", 32'h3F800000, 32'h40000000, OP_SUB,
                 0, 0, 31'h40000000, 31'h3F800000, 1, 1);
        directed("small_x_add", 32'h3F800000, 32'h40000000, OP_ADD,
                 0, 0, 31'h40000000, 31'h3F800000, 0, 0);

        // Backpressure: six pairs against a repeating out_ready pattern.
        idle(3);
        sent = 0;
        seen_block = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            out_ready = pat[i % 6] != 0;
            if (sent < 6) begin
                in_valid   = 1;
                data_x_i   = 32'h40000000 + 32'(sent * 32'h00100000);
                data_y_i   = 32'hC0200000 - 32'(sent * 32'h00080000);
                add_subt_i = sent[0];
            end else begin
                in_valid = 0;
            end
            #1;
            if (in_valid && !in_ready) seen_block = 1;
            if (in_valid && in_ready) sent++;
        end
        check("bp_all_sent", sent, 6);
        check("bp_in_ready_blocked", seen_block, 1);
        drain();

        // Full throughput: out_valid every cycle from the third on.
        idle(3);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            out_ready = 1;
            if (k >= 2) check("throughput_valid", out_valid, 1);
            in_valid = (k < 8);
            if (k < 8) rand_pair();
        end
        drain();

        // Reset with two pairs in flight.
        idle(3);
        @(posedge clk); #1;
        out_ready = 0; in_valid = 1; rand_pair();
        @(posedge clk); #1;
        rand_pair();
        @(posedge clk); #1;
        rst_n = 0; in_valid = 1;
        #1;
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1; in_valid = 0; out_ready = 1;
        check("rst_flush", {out_valid, dut_pay()}, 0);
        directed("after_reset", 32'hC1200000, 32'h41200000, OP_SUB,
                 0, 1, 31'h41200000, 31'h41200000, 1, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst_n     = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            rand_pair();
        end
        @(posedge clk); #1;
        rst_n = 1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
